// File: rtl/aes_spi_slave_if.sv
// SPI bus between the serial-link master and the AES-side frame engine (mode 0, MSB first).
interface aes_spi_slave_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs, sclk, mosi, input miso);
  modport slave  (input cs, sclk, mosi, output miso);
endinterface

// File: rtl/aes_spi_slave.sv
// Full-duplex SPI slave frame engine: oversamples cs/sclk/mosi, receives and sends 392-bit frames.
// Optional build macro SPI_SLAVE_KEYSIZE_CHECK_EN rejects frames whose key-size byte is not 16/24/32.
module aes_spi_slave #(
  parameter int FRAME_BITS  = 392,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_spi_slave_if.slave        spi,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   rx_shift;
  logic [FRAME_BITS-1:0]   tx_shift;
  logic                    miso_q;

  logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync, mosi_sync;
  logic                    cs_hist, sclk_hist;
  logic                    cs_s, sclk_s, mosi_s;
  logic                    cs_rise, cs_fall, sclk_rise, sclk_fall;

  // Synchronisers clear to 0 so that cs still held low across a reset
  // never looks like a fresh falling edge: the interrupted frame is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_hist   <= 1'b0;
      sclk_hist <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop in the chain samples pre-edge values.
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi.cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      cs_hist   <= cs_s;
      sclk_hist <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = ~cs_s & cs_hist;
  assign cs_rise   = cs_s & ~cs_hist;
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;

`ifdef SPI_SLAVE_KEYSIZE_CHECK_EN
  logic key_ok;
  assign key_ok = (rx_shift[263:256] == 8'd16) || (rx_shift[263:256] == 8'd24) ||
                  (rx_shift[263:256] == 8'd32);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide shift and data registers are reset too, because their
      // cleared contents are visible on miso and rx_data right after reset.
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso_q    <= (state == SHIFT) & tx_shift[FRAME_BITS-1];

      case (state)
        IDLE: begin
          // A load coinciding with cs falling still lands before the first shift.
          if (tx_load) tx_shift <= tx_data;
          if (cs_fall) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt == CNT_W'(FRAME_BITS)) begin
`ifdef SPI_SLAVE_KEYSIZE_CHECK_EN
            if (key_ok) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
`else
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
`endif
            state <= DONE;
          end else if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
              bit_cnt  <= bit_cnt + 1'b1;
            end
            if (sclk_fall) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
          end
        end

        DONE: begin
          if (cs_rise) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign spi.miso = miso_q;
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_aes_spi_slave.sv
// Randomised self-checking bench for aes_spi_slave: a frame-level model predicts rx_data,
// pulse counts and the miso stream for directed and random SPI frames.
module tb_aes_spi_slave;
  localparam int FB = 392;

  logic          clk = 1'b0;
  logic          reset;
  logic [FB-1:0] tx_data;
  logic          tx_load;
  logic [FB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;

  aes_spi_slave_if spi_bus ();

  aes_spi_slave dut (
    .clk       (clk),
    .reset     (reset),
    .spi       (spi_bus.slave),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [FB-1:0] exp_rx;
  logic [FB-1:0] tx_model;
  bit            tx_known;
  logic [FB-1:0] miso_cap;

  // Pulse and busy monitors
  int valid_cnt  = 0;
  int err_cnt    = 0;
  bit busy_win   = 1'b0;
  int busy_drops = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid)  valid_cnt++;
      if (frame_err) err_cnt++;
      if (busy_win && !busy) busy_drops++;
    end
  end

  task automatic check(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit frame_accepted(input logic [7:0] ks);
`ifdef SPI_SLAVE_KEYSIZE_CHECK_EN
    return (ks == 8'd16) || (ks == 8'd24) || (ks == 8'd32);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [FB-1:0] make_frame(input logic [127:0] text, input logic [7:0] ks,
                                               input logic [255:0] key);
    logic [255:0] mask;
    mask = (ks >= 8'd32) ? {256{1'b1}} : ({256{1'b1}} << (256 - 8 * int'(ks)));
    return {text, ks, key & mask};
  endfunction

  function automatic logic [FB-1:0] rand_vec();
    logic [FB-1:0] v;
    for (int i = 0; i < FB; i += 32) v[i +: 8] = 8'($urandom);
    for (int i = 0; i < FB; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [FB-1:0] val);
    tx_data = val;
    tx_load = 1'b1;
    wait_cyc(1);
    tx_load  = 1'b0;
    tx_model = val;
    tx_known = 1'b1;
  endtask

  task automatic cs_low();
    spi_bus.cs = 1'b0;
    wait_cyc(6);
  endtask

  task automatic cs_high();
    wait_cyc(6);
    busy_win   = 1'b0;
    spi_bus.cs = 1'b1;
    wait_cyc(8);
  endtask

  // Master side, mode 0: mosi set while sclk low, miso sampled just before the rising edge.
  task automatic shift_bits(input logic [FB-1:0] req, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      spi_bus.mosi = req[FB-1-i];
      wait_cyc(5);
      miso_cap[FB-1-i] = spi_bus.miso;
      spi_bus.sclk = 1'b1;
      wait_cyc(5);
      spi_bus.sclk = 1'b0;
    end
  endtask

  // Predict and check the outcome of a frame whose bits were already shifted.
  task automatic judge(input string tag, input logic [FB-1:0] req, input int nbits,
                       input int v0, input int e0);
    int            exp_v, exp_e;
    logic [FB-1:0] mask;
    exp_v = 0;
    exp_e = 1;
    if (nbits == FB && frame_accepted(req[263:256])) begin
      exp_rx = req;
      exp_v  = 1;
      exp_e  = 0;
    end
    check({tag, ".rx_data"},   rx_data, exp_rx);
    check({tag, ".rx_valid"},  FB'(valid_cnt - v0), FB'(exp_v));
    check({tag, ".frame_err"}, FB'(err_cnt - e0),   FB'(exp_e));
    if (tx_known) begin
      mask = {FB{1'b1}} << (FB - nbits);
      check({tag, ".miso"}, miso_cap & mask, tx_model & mask);
    end
    tx_known = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [FB-1:0] req, input int nbits);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    miso_cap = '0;
    cs_low();
    shift_bits(req, 0, nbits);
    cs_high();
    judge(tag, req, nbits, v0, e0);
  endtask

  initial begin
    logic [FB-1:0] req, busy_tx;
    logic [255:0]  key;
    logic [7:0]    ks;
    int            v0, e0;

    reset        = 1'b1;
    spi_bus.cs   = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.mosi = 1'b0;
    tx_data      = '0;
    tx_load      = 1'b0;
    exp_rx       = '0;
    tx_model     = '0;
    tx_known     = 1'b1;
    miso_cap     = '0;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);

    check("reset.miso",      FB'(spi_bus.miso), '0);
    check("reset.rx_valid",  FB'(rx_valid),     '0);
    check("reset.frame_err", FB'(frame_err),    '0);
    check("reset.busy",      FB'(busy),         '0);
    check("reset.rx_data",   rx_data,           '0);

    // Full request frame with no prior load: response stream is the reset value 0.
    req = {128'h00112233445566778899aabbccddeeff, 8'd16,
           128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    do_frame("full", req, FB);

    // Response shifting
    load_tx({128'h69c4e0d86a7b0430d8cdb78070b4c55a, 264'h0});
    do_frame("resp", make_frame(128'($urandom), 8'd16, rand_vec()[255:0]), FB);

    // Early abort after 100 bits, then a full 24-byte-key frame
    load_tx(rand_vec());
    do_frame("abort", rand_vec(), 100);
    check("abort.busy", FB'(busy), '0);
    load_tx(rand_vec());
    do_frame("after_abort", make_frame(rand_vec()[127:0], 8'd24, rand_vec()[255:0]), FB);

    // Unsupported key size
    load_tx(rand_vec());
    req = make_frame(rand_vec()[127:0], 8'd20, rand_vec()[255:0]);
    do_frame("ks20", req, FB);
`ifndef SPI_SLAVE_KEYSIZE_CHECK_EN
    check("ks20.keysize", FB'(rx_data[263:256]), FB'(8'h14));
`endif

    // Reset mid-frame: remainder of the interrupted frame must be ignored
    v0  = valid_cnt;
    e0  = err_cnt;
    req = rand_vec();
    cs_low();
    shift_bits(req, 0, 200);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    shift_bits(req, 200, FB - 200);
    check("rst_mid.busy", FB'(busy), '0);
    cs_high();
    check("rst_mid.rx_valid",  FB'(valid_cnt - v0), '0);
    check("rst_mid.frame_err", FB'(err_cnt - e0),   '0);
    exp_rx = '0;
    check("rst_mid.rx_data", rx_data, exp_rx);
    for (int i = 0; i < 32; i++) key[255 - 8 * i -: 8] = 8'(i);
    load_tx(rand_vec());
    do_frame("fresh32", make_frame(rand_vec()[127:0], 8'd32, key), FB);

    // tx_load while shifting is ignored and busy holds
    busy_tx = rand_vec();
    load_tx(busy_tx);
    req      = make_frame(rand_vec()[127:0], 8'd16, rand_vec()[255:0]);
    v0       = valid_cnt;
    e0       = err_cnt;
    miso_cap = '0;
    cs_low();
    busy_win = 1'b1;
    shift_bits(req, 0, 50);
    tx_data = {FB{1'b1}};
    tx_load = 1'b1;
    wait_cyc(1);
    tx_load = 1'b0;
    shift_bits(req, 50, FB - 50);
    cs_high();
    check("ld_busy.busy_drops", FB'(busy_drops), '0);
    judge("ld_busy", req, FB, v0, e0);

    // Random frames, mostly legal key sizes, some arbitrary
    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 3))
        0:       ks = 8'd16;
        1:       ks = 8'd24;
        2:       ks = 8'd32;
        default: ks = 8'($urandom);
      endcase
      load_tx(rand_vec());
      do_frame($sformatf("rand%0d", n), make_frame(rand_vec()[127:0], ks, rand_vec()[255:0]), FB);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aes_spi_slave.md
# aes_spi_slave

SPI slave frame engine on the AES core side of the serial link; the counterpart of the master that shifts 392-bit frames. It deserialises one 392-bit request frame into rx_data: bits [391:264] are the 128-bit text, [263:256] the key size in bytes, and [255:0] the key, left-aligned and zero-padded. During the same chip-select window it serialises a previously loaded 392-bit response frame onto miso, full duplex. All SPI inputs are oversampled in the single system clock domain.

## Interface
- FRAME_BITS, 392, bits per frame; the bit counter width is ceil(log2(FRAME_BITS+1)) = 9.
- SYNC_STAGES, 2, synchroniser depth applied to sclk, cs and mosi.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- cs  input  1  chip select, active low, asynchronous to clk.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first; 0 when not selected.
- tx_data  input  392  response frame.
- tx_load  input  1  one-cycle strobe; captures tx_data while in IDLE.
- rx_data  output  392  last complete request frame; held until the next valid frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when cs deasserts before FRAME_BITS bits.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Each of cs, sclk and mosi passes through SYNC_STAGES flops and then one extra history flop. Edges are detected from the synchronised output and the history flop.
- State IDLE:
  - tx_load captures tx_data into tx_shift. With no load since reset, tx_shift is 0.
  - A cs falling edge clears bit_cnt and moves to SHIFT.
- State SHIFT:
  - On an sclk rising edge: rx_shift <= {rx_shift[390:0], mosi_s} and bit_cnt increments.
  - On an sclk falling edge: tx_shift <= {tx_shift[390:0], 1'b0}.
  - When bit_cnt reaches FRAME_BITS, the next cycle copies rx_shift to rx_data, pulses rx_valid, and moves to DONE.
  - A cs rising edge with bit_cnt < FRAME_BITS pulses frame_err, leaves rx_data unchanged, and returns to IDLE.
- State DONE:
  - Further sclk edges are ignored and miso is 0.
  - A cs rising edge returns to IDLE.
  - tx_shift is not reloaded automatically; the owner must issue tx_load before the next frame.
- miso is tx_shift[391] in SHIFT and 0 otherwise. The MSB is therefore valid before the first rising edge of sclk.
- tx_load outside IDLE is ignored, and tx_shift is not corrupted.
- If a cs falling edge and a tx_load strobe land on the same cycle in IDLE, the load wins and the frame still starts with the new data.
- Reset mid-frame forces IDLE, clears the counters and pulses nothing. Because IDLE waits for a cs falling edge, the remainder of a frame already in progress (cs still low) is ignored.

## Timing
- Reset values:
  - miso = 0, rx_valid = 0, frame_err = 0, busy = 0.
  - rx_data = 0, tx_shift = 0, rx_shift = 0.
  - State IDLE, bit_cnt = 0.
- Input latency: SYNC_STAGES + 1 clk cycles from a pin transition to edge detection.
- rx_valid asserts exactly 1 cycle after the cycle in which the 392nd rising edge is detected.
- frame_err asserts on the cycle the cs rising edge is detected.
- miso changes 1 cycle after a detected sclk falling edge, i.e. 4 clk cycles after the pin edge.
- Constraints on the master:
  - sclk high and low phases are each at least 4 clk cycles.
  - cs falls at least 4 clk cycles before the first sclk rising edge.
  - cs rises at least 4 clk cycles after the last sclk falling edge.

## Configuration
- SPI_SLAVE_KEYSIZE_CHECK_EN defined: on frame completion, rx_shift[263:256] is checked against {16, 24, 32}.
  - Any other value: frame_err pulses instead of rx_valid, rx_data is unchanged, and the state still moves to DONE.
- SPI_SLAVE_KEYSIZE_CHECK_EN undefined: every complete frame produces rx_valid regardless of the key-size byte.

## Test plan
- Full request frame:
  - Stimulus: send {128'h00112233445566778899aabbccddeeff, 8'd16, 128'h000102030405060708090a0b0c0d0e0f, 128'h0}.
  - Response: rx_data equals the frame exactly; rx_valid is high for 1 cycle; frame_err stays 0.
- Response shifting:
  - Stimulus: tx_load with tx_data = {128'h69c4e0d86a7b0430d8cdb78070b4c55a, 264'h0}, then a 392-bit frame.
  - Response: the first 128 miso bits sampled on sclk rising edges equal 69c4e0d8…c55a, and the remaining 264 bits are 0.
- Early abort:
  - Stimulus: raise cs after 100 bits.
  - Response: frame_err pulses once, rx_valid stays 0, rx_data holds its previous value. A following full 8'd24 frame is received correctly.
- Key-size check:
  - Stimulus: a full frame with key size 8'd20.
  - Response with the macro defined: frame_err pulses and there is no rx_valid.
  - Response without the macro: rx_valid pulses and rx_data[263:256] = 8'h14.
- Reset mid-frame:
  - Stimulus: assert reset after 200 bits, release it, continue clocking to 392 bits with cs still low, then run a fresh cs cycle with 8'd32 and key 000102…1f.
  - Response: no rx_valid for the interrupted frame, then rx_valid and a matching rx_data for the fresh frame.
- Load while busy:
  - Stimulus: tx_load during SHIFT with tx_data all ones.
  - Response: the miso stream for the current frame is unchanged; busy = 1 throughout.
